// File: rtl/fetch_unit.sv
// Instruction fetch unit: latches opcode/operand bytes from ROM, tracks fetch
// sequencing with a small FSM and maintains the program counter.
module fetch_unit #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    fetch,
    input  logic          PC_en,
    input  logic          pc_chg_en,
    input  logic          ad_sel,
    input  logic [DW-1:0] rom_data,
    output logic [3:0]    ins,
    output logic [3:0]    reg_addr,
    output logic [AW-1:0] operand,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] addr,
    output logic          ir_valid,
    output logic          opnd_valid,
    output logic          seq_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OPC   = 2'd1,
        OPND  = 2'd2
    } fetchState_t;

    fetchState_t   r_state;
    logic [3:0]    r_ins;
    logic [3:0]    r_regAddr;
    logic [AW-1:0] r_operand;
    logic [AW-1:0] r_pc;
    logic          r_irValid;
    logic          r_opndValid;
    logic          r_seqErr;
    logic [AW-1:0] w_romOp;

    // Operand/jump target is the ROM byte resized to the address width.
    generate
        if (AW <= DW) begin : g_romTrunc
            assign w_romOp = rom_data[AW-1:0];
        end else begin : g_romExt
            assign w_romOp = {{(AW-DW){1'b0}}, rom_data};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_ins       <= 4'h0;
            r_regAddr   <= 4'h0;
            r_operand   <= '0;
            r_pc        <= '0;
            r_irValid   <= 1'b0;
            r_opndValid <= 1'b0;
            r_seqErr    <= 1'b0;
        end else begin
            r_seqErr <= 1'b0;
            case (fetch)
                2'b01: begin
                    r_ins       <= rom_data[7:4];
                    r_regAddr   <= rom_data[3:0];
                    r_state     <= OPC;
                    r_irValid   <= 1'b1;
                    r_opndValid <= 1'b0;
                end
                2'b10: begin
                    if (r_state == EMPTY) begin
                        r_seqErr <= 1'b1;
                    end else begin
                        r_operand   <= w_romOp;
                        r_state     <= OPND;
                        r_opndValid <= 1'b1;
                    end
                end
                2'b11: begin
                    r_seqErr <= 1'b1;
                end
                default: begin
                end
            endcase

            // PC path is decoupled from the fetch FSM; a jump taken while the
            // operand is being fetched uses the ROM byte directly.
            if (PC_en) begin
                if (pc_chg_en) begin
                    if (fetch == 2'b10) begin
                        r_pc <= w_romOp;
                    end else begin
                        r_pc <= r_operand;
                    end
                end else begin
                    r_pc <= r_pc + AW'(1);
                end
            end
        end
    end

    assign ins        = r_ins;
    assign reg_addr   = r_regAddr;
    assign operand    = r_operand;
    assign pc         = r_pc;
    assign ir_valid   = r_irValid;
    assign opnd_valid = r_opndValid;
    assign seq_err    = r_seqErr;
    assign addr       = ad_sel ? r_operand : r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: each task drives one scenario and checks
// outputs one time unit after the rising edge.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [1:0] fetch;
    logic       PC_en;
    logic       pc_chg_en;
    logic       ad_sel;
    logic [7:0] rom_data;
    logic [3:0] ins;
    logic [3:0] reg_addr;
    logic [7:0] operand;
    logic [7:0] pc;
    logic [7:0] addr;
    logic       ir_valid;
    logic       opnd_valid;
    logic       seq_err;

    int nCompared;
    int nMismatched;

    fetch_unit #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch),
        .PC_en      (PC_en),
        .pc_chg_en  (pc_chg_en),
        .ad_sel     (ad_sel),
        .rom_data   (rom_data),
        .ins        (ins),
        .reg_addr   (reg_addr),
        .operand    (operand),
        .pc         (pc),
        .addr       (addr),
        .ir_valid   (ir_valid),
        .opnd_valid (opnd_valid),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic pe, input logic chg, input logic [7:0] rd);
        fetch = f; PC_en = pe; pc_chg_en = chg; rom_data = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; ad_sel = 1'b0;
        drive(2'b01, 1'b1, 1'b0, 8'hFF);
        tick(); tick();
        nCompared++; if (pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h want 00", pc); end
        nCompared++; if (ins !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_ins: got %h want 0", ins); end
        nCompared++; if (reg_addr !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_reg: got %h want 0", reg_addr); end
        nCompared++; if (operand !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_operand: got %h want 00", operand); end
        nCompared++; if ({ir_valid, opnd_valid, seq_err} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b want 000", {ir_valid, opnd_valid, seq_err}); end
        nCompared++; if (addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_addr_pc: got %h want 00", addr); end
        ad_sel = 1'b1; #1;
        nCompared++; if (addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_addr_opnd: got %h want 00", addr); end
        ad_sel = 1'b0;
    endtask

    task automatic test_short_op();
        rst = 1'b0;
        drive(2'b01, 1'b1, 1'b0, 8'h63);
        tick();
        nCompared++; if (ins !== 4'h6) begin nMismatched++; $display("[TB] FAIL short_ins: got %h want 6", ins); end
        nCompared++; if (reg_addr !== 4'h3) begin nMismatched++; $display("[TB] FAIL short_reg: got %h want 3", reg_addr); end
        nCompared++; if (pc !== 8'h01) begin nMismatched++; $display("[TB] FAIL short_pc: got %h want 01", pc); end
        nCompared++; if ({ir_valid, opnd_valid} !== 2'b10) begin nMismatched++; $display("[TB] FAIL short_valid: got %b want 10", {ir_valid, opnd_valid}); end
        nCompared++; if (addr !== 8'h01) begin nMismatched++; $display("[TB] FAIL short_addr: got %h want 01", addr); end
    endtask

    task automatic test_long_op();
        drive(2'b01, 1'b0, 1'b0, 8'h2A);
        tick();
        nCompared++; if ({ins, reg_addr} !== 8'h2A) begin nMismatched++; $display("[TB] FAIL long_opc: got %h want 2A", {ins, reg_addr}); end
        nCompared++; if (opnd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL long_opnd_valid0: got %b want 0", opnd_valid); end
        drive(2'b10, 1'b0, 1'b0, 8'h5C);
        tick();
        nCompared++; if (operand !== 8'h5C) begin nMismatched++; $display("[TB] FAIL long_operand: got %h want 5C", operand); end
        nCompared++; if ({ins, ir_valid, opnd_valid} !== 6'b0010_11) begin nMismatched++; $display("[TB] FAIL long_state: got %b want 001011", {ins, ir_valid, opnd_valid}); end
        drive(2'b00, 1'b0, 1'b0, 8'hFF);
        ad_sel = 1'b1; #1;
        nCompared++; if (addr !== 8'h5C) begin nMismatched++; $display("[TB] FAIL long_addr: got %h want 5C", addr); end
        ad_sel = 1'b0; #1;
        nCompared++; if (addr !== 8'h01) begin nMismatched++; $display("[TB] FAIL long_addr_pc: got %h want 01", addr); end
        tick();
        nCompared++; if ({ins, reg_addr, operand, pc} !== 24'h2A_5C_01) begin nMismatched++; $display("[TB] FAIL hold: got %h want 2A5C01", {ins, reg_addr, operand, pc}); end
    endtask

    task automatic test_jump_bypass();
        drive(2'b10, 1'b0, 1'b0, 8'h10);
        tick();
        drive(2'b00, 1'b1, 1'b1, 8'hEE);
        tick();
        nCompared++; if (pc !== 8'h10) begin nMismatched++; $display("[TB] FAIL jump_operand_pc: got %h want 10", pc); end
        drive(2'b00, 1'b0, 1'b1, 8'hEE);
        tick();
        nCompared++; if (pc !== 8'h10) begin nMismatched++; $display("[TB] FAIL jump_disabled_pc: got %h want 10", pc); end
        drive(2'b10, 1'b1, 1'b1, 8'h80);
        tick();
        nCompared++; if (pc !== 8'h80) begin nMismatched++; $display("[TB] FAIL bypass_pc: got %h want 80", pc); end
        nCompared++; if (operand !== 8'h80) begin nMismatched++; $display("[TB] FAIL bypass_operand: got %h want 80", operand); end
    endtask

    task automatic test_wrap();
        drive(2'b10, 1'b1, 1'b1, 8'hFF);
        tick();
        nCompared++; if (pc !== 8'hFF) begin nMismatched++; $display("[TB] FAIL wrap_setup_pc: got %h want FF", pc); end
        drive(2'b00, 1'b1, 1'b0, 8'h00);
        tick();
        nCompared++; if (pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL wrap_pc: got %h want 00", pc); end
        nCompared++; if ({ins, reg_addr, operand} !== 16'h2A_FF) begin nMismatched++; $display("[TB] FAIL wrap_regs: got %h want 2AFF", {ins, reg_addr, operand}); end
        nCompared++; if ({ir_valid, opnd_valid, seq_err} !== 3'b110) begin nMismatched++; $display("[TB] FAIL wrap_flags: got %b want 110", {ir_valid, opnd_valid, seq_err}); end
        drive(2'b01, 1'b1, 1'b0, 8'h9B);
        tick();
        nCompared++; if ({ins, reg_addr, pc} !== 16'h9B_01) begin nMismatched++; $display("[TB] FAIL opc_inc: got %h want 9B01", {ins, reg_addr, pc}); end
        nCompared++; if ({opnd_valid, operand} !== 9'h0FF) begin nMismatched++; $display("[TB] FAIL opc_inc_opnd: got %h want 0FF", {opnd_valid, operand}); end
    endtask

    task automatic test_illegal();
        rst = 1'b1; drive(2'b00, 1'b0, 1'b0, 8'h00);
        tick();
        rst = 1'b0;
        drive(2'b10, 1'b0, 1'b0, 8'h77);
        tick();
        nCompared++; if (seq_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL empty_opnd_err: got %b want 1", seq_err); end
        nCompared++; if ({operand, ir_valid, opnd_valid} !== 10'h000) begin nMismatched++; $display("[TB] FAIL empty_opnd_regs: got %h want 000", {operand, ir_valid, opnd_valid}); end
        drive(2'b01, 1'b0, 1'b0, 8'h4E);
        tick();
        nCompared++; if (seq_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_pulse_width: got %b want 0", seq_err); end
        drive(2'b11, 1'b1, 1'b0, 8'h11);
        tick();
        nCompared++; if (seq_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL illegal11_err: got %b want 1", seq_err); end
        nCompared++; if ({ins, reg_addr, ir_valid, opnd_valid} !== 10'b0100_1110_10) begin nMismatched++; $display("[TB] FAIL illegal11_regs: got %b want 0100111010", {ins, reg_addr, ir_valid, opnd_valid}); end
        nCompared++; if (pc !== 8'h01) begin nMismatched++; $display("[TB] FAIL illegal11_pc: got %h want 01", pc); end
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        tick();
        nCompared++; if (seq_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal11_clear: got %b want 0", seq_err); end
    endtask

    task automatic test_reset_mid_op();
        drive(2'b10, 1'b0, 1'b0, 8'h33);
        tick();
        nCompared++; if (opnd_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL midop_setup: got %b want 1", opnd_valid); end
        rst = 1'b1; drive(2'b01, 1'b1, 1'b1, 8'hC5);
        tick();
        nCompared++; if ({ins, reg_addr, operand, pc} !== 24'h00_00_00) begin nMismatched++; $display("[TB] FAIL midop_regs: got %h want 000000", {ins, reg_addr, operand, pc}); end
        nCompared++; if ({ir_valid, opnd_valid, seq_err, addr} !== 11'h000) begin nMismatched++; $display("[TB] FAIL midop_flags: got %h want 000", {ir_valid, opnd_valid, seq_err, addr}); end
        rst = 1'b0; drive(2'b10, 1'b0, 1'b0, 8'h12);
        tick();
        nCompared++; if ({seq_err, operand} !== 9'h100) begin nMismatched++; $display("[TB] FAIL midop_empty: got %h want 100", {seq_err, operand}); end
    endtask

    task automatic test_back_to_back();
        drive(2'b01, 1'b0, 1'b0, 8'h1F);
        tick();
        drive(2'b10, 1'b0, 1'b0, 8'h20);
        tick();
        drive(2'b10, 1'b0, 1'b0, 8'h21);
        tick();
        nCompared++; if ({operand, opnd_valid, seq_err} !== 10'b0010_0001_10) begin nMismatched++; $display("[TB] FAIL b2b_opnd: got %b want 0010000110", {operand, opnd_valid, seq_err}); end
        drive(2'b01, 1'b0, 1'b0, 8'h3C);
        tick();
        nCompared++; if ({ins, reg_addr, operand} !== 16'h3C_21) begin nMismatched++; $display("[TB] FAIL b2b_opc_regs: got %h want 3C21", {ins, reg_addr, operand}); end
        nCompared++; if ({ir_valid, opnd_valid} !== 2'b10) begin nMismatched++; $display("[TB] FAIL b2b_opc_valid: got %b want 10", {ir_valid, opnd_valid}); end
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        rst = 1'b1; ad_sel = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_short_op();
        test_long_op();
        test_jump_bypass();
        test_wrap();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, default 8, sets the PC, operand and address width in bits.
REQ-002 Parameter DW, default 8, sets the ROM data byte width; the opcode is DW[7:4] and the register index is DW[3:0].
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 fetch  in  2  01 latches the opcode byte; 10 latches the operand byte; 00 holds; 11 is illegal.
REQ-006 PC_en  in  1  PC update enable.
REQ-007 pc_chg_en  in  1  with PC_en, selects PC load (jump) instead of increment.
REQ-008 ad_sel  in  1  address source select: 0 selects the PC, 1 selects the operand.
REQ-009 rom_data  in  DW  ROM read data for the current address.
REQ-010 ins  out  4  opcode to the controller; it drives the controller `ins` input.
REQ-011 reg_addr  out  4  register index taken from the opcode byte's low nibble.
REQ-012 operand  out  AW  second byte of a long instruction.
REQ-013 pc  out  AW  program counter.
REQ-014 addr  out  AW  memory address.
REQ-015 ir_valid  out  1  high when an opcode is held.
REQ-016 opnd_valid  out  1  high when an operand is held for the current opcode.
REQ-017 seq_err  out  1  one-cycle pulse on an illegal or out-of-order fetch.

Function
REQ-018 The block SHALL implement a 3-state FSM with states EMPTY, OPC and OPND.
REQ-019 EMPTY SHALL be the state after reset.
REQ-020 fetch=01 in any state SHALL load ins<=rom_data[7:4], load reg_addr<=rom_data[3:0], clear opnd_valid and go to OPC.
REQ-021 fetch=10 in OPC or OPND SHALL load operand<=rom_data[AW-1:0] and go to or stay in OPND.
REQ-022 fetch=10 in EMPTY SHALL leave all registers unchanged, stay in EMPTY and pulse seq_err.
REQ-023 fetch=11 in any state SHALL leave all registers and the state unchanged and pulse seq_err.
REQ-024 fetch=00 SHALL hold the state, ins, reg_addr and operand.
REQ-025 ir_valid SHALL be 1 in OPC and OPND; opnd_valid SHALL be 1 only in OPND. Both SHALL be registered.
REQ-026 PC_en=1 with pc_chg_en=0 SHALL set pc<=pc+1 modulo 2^AW (for AW=8, 0xFF wraps to 0x00 with no flag).
REQ-027 PC_en=1 with pc_chg_en=1 and fetch=10 in the same cycle SHALL set pc<=rom_data (bypass) and also update operand.
REQ-028 PC_en=1 with pc_chg_en=1 and fetch≠10 SHALL set pc<=operand.
REQ-029 pc_chg_en=1 with PC_en=0 SHALL leave pc unchanged.
REQ-030 PC update SHALL be independent of fetch decoding; fetch=01 with PC_en=1 in the same cycle SHALL latch the opcode from the pre-increment address and increment pc.
REQ-031 addr SHALL be combinational: ad_sel ? operand : pc. It SHALL carry no added latency.
REQ-032 Latency SHALL be as follows: ins, reg_addr, operand and pc are valid 1 cycle after the qualifying edge; seq_err is high for exactly the cycle after the offending input.
REQ-033 rom_data SHALL be sampled only on cycles where fetch=01 or fetch=10.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL set pc=0, ins=0 (NOP), reg_addr=0, operand=0, ir_valid=0, opnd_valid=0 and seq_err=0, and SHALL enter EMPTY.
REQ-035 rst SHALL take priority over every simultaneous fetch, PC_en or pc_chg_en input.
REQ-036 rst asserted mid-instruction, including in OPND, SHALL discard all held bytes.
REQ-037 addr SHALL equal 0 during reset, because it is derived from the reset registers.

Verification
REQ-038 Short op: reset, then fetch=01 with rom_data=0x63 and PC_en=1 -> next cycle ins=0x6, reg_addr=0x3, pc=0x01, ir_valid=1, opnd_valid=0.
REQ-039 Long op: fetch=01 with rom_data=0x2A, then fetch=10 with rom_data=0x5C, then ad_sel=1 -> ins=0x2, operand=0x5C, opnd_valid=1, addr=0x5C.
REQ-040 Jump bypass: pc=0x10, then fetch=10, PC_en=1, pc_chg_en=1 with rom_data=0x80 -> next cycle pc=0x80, operand=0x80.
REQ-041 Wrap: pc=0xFF, PC_en=1, pc_chg_en=0 -> pc=0x00, no other output changes.
REQ-042 Illegal sequences: fetch=10 in EMPTY -> seq_err=1 for one cycle with operand=0; fetch=11 in OPC -> seq_err=1 with ins unchanged.
REQ-043 Reset mid-op: in OPND, rst=1 together with fetch=01 -> next cycle all outputs at reset values, state EMPTY, and the opcode not latched.
